// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared stack micro-op encodings, flags width and ret_fsm states
package processor_pkg;

   localparam logic [15:0] NOP_OP          = 16'b0000000000000000;
   localparam logic [15:0] PUSH_PC_LOW_OP  = 16'b0110000000001000;
   localparam logic [15:0] PUSH_PC_HIGH_OP = 16'b0110000000001001;
   localparam logic [15:0] POP_PC_HIGH_OP  = 16'b0110000000001010;
   localparam logic [15:0] POP_PC_LOW_OP   = 16'b0110000000001011;
   localparam logic [15:0] POP_FLAGS_OP    = 16'b0110000000001100;

   localparam int FLAG_W = 4;

   typedef enum logic [2:0] {
      RET_IDLE      = 3'd0,
      RET_POP_HIGH  = 3'd1,
      RET_POP_LOW   = 3'd2,
      RET_POP_FLAGS = 3'd3,
      RET_WAIT_DATA = 3'd4,
      RET_CHANGE_PC = 3'd5
   } ret_state_t;

endpackage

// File: rtl/pop_collector.sv
// rtl/pop_collector.sv - gathers popped words in issue order into the restored PC and flags
module pop_collector
   import processor_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic              i_enable,
   input  logic              i_is_rti,
   input  logic              i_pop_valid,
   input  logic [15:0]       i_pop_data,
   output logic [31:0]       o_pc,
   output logic [FLAG_W-1:0] o_flags,
   output logic              o_done
);

   logic [1:0]        r_count;
   logic [31:0]       r_pc;
   logic [FLAG_W-1:0] r_flags;
   logic [1:0]        w_expected;
   logic              w_done;

   assign w_expected = i_is_rti ? 2'd3 : 2'd2;
   assign w_done     = (r_count == w_expected);

   // Only the count is cleared on start; pc/flags keep their value until overwritten.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= 2'd0;
         r_pc    <= 32'd0;
         r_flags <= '0;
      end else if (i_start) begin
         r_count <= 2'd0;
      end else if (i_enable && i_pop_valid && !w_done) begin
         case (r_count)
            2'd0:    r_pc[31:16] <= i_pop_data;
            2'd1:    r_pc[15:0]  <= i_pop_data;
            default: r_flags     <= i_pop_data[FLAG_W-1:0];
         endcase
         r_count <= r_count + 2'd1;
      end
   end

   assign o_pc    = r_pc;
   assign o_flags = r_flags;
   assign o_done  = w_done;

endmodule

// File: rtl/ret_fsm.sv
// rtl/ret_fsm.sv - RET/RTI sequencer: injects stack pops, then redirects fetch to the restored PC
module ret_fsm
   import processor_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              ret,
   input  logic              rti,
   input  logic              pop_valid,
   input  logic [15:0]       pop_data,
   output logic [15:0]       out,
   output logic              stall,
   output logic [31:0]       pc,
   output logic              change_pc_ret,
   output logic [FLAG_W-1:0] flags_out,
   output logic              flags_restore
);

   ret_state_t  r_state;
   ret_state_t  w_next;
   logic        r_is_rti;
   logic        w_is_rti_next;
   logic        w_start;
   logic        w_capture_en;
   logic        w_done;
   logic [15:0] r_out;
   logic [15:0] w_out;
   logic        r_stall;
   logic        w_stall;
   logic        r_change_pc;
   logic        w_change_pc;
   logic        r_flags_restore;
   logic        w_flags_restore;

   // Returns may overlap pop issue, so capture is open in every active state but CHANGE_PC.
   assign w_capture_en = (r_state != RET_IDLE) && (r_state != RET_CHANGE_PC);

   pop_collector u_pop_collector (
      .clk         (clk),
      .reset       (reset),
      .i_start     (w_start),
      .i_enable    (w_capture_en),
      .i_is_rti    (r_is_rti),
      .i_pop_valid (pop_valid),
      .i_pop_data  (pop_data),
      .o_pc        (pc),
      .o_flags     (flags_out),
      .o_done      (w_done)
   );

   always_comb begin
      w_next        = r_state;
      w_start       = 1'b0;
      w_is_rti_next = r_is_rti;
      case (r_state)
         RET_IDLE: begin
            if (rti) begin
               w_next        = RET_POP_HIGH;
               w_start       = 1'b1;
               w_is_rti_next = 1'b1;
            end else if (ret) begin
               w_next        = RET_POP_HIGH;
               w_start       = 1'b1;
               w_is_rti_next = 1'b0;
            end
         end
         RET_POP_HIGH:  w_next = RET_POP_LOW;
         RET_POP_LOW:   w_next = r_is_rti ? RET_POP_FLAGS : RET_WAIT_DATA;
         RET_POP_FLAGS: w_next = RET_WAIT_DATA;
         RET_WAIT_DATA: if (w_done) w_next = RET_CHANGE_PC;
         RET_CHANGE_PC: w_next = RET_IDLE;
         default:       w_next = RET_IDLE;
      endcase

      // Outputs are decoded from the next state and registered alongside it.
      w_out = NOP_OP;
      case (w_next)
         RET_POP_HIGH:  w_out = POP_PC_HIGH_OP;
         RET_POP_LOW:   w_out = POP_PC_LOW_OP;
         RET_POP_FLAGS: w_out = POP_FLAGS_OP;
         default:       w_out = NOP_OP;
      endcase
      w_stall         = (w_next != RET_IDLE);
      w_change_pc     = (w_next == RET_CHANGE_PC);
      w_flags_restore = w_change_pc && r_is_rti;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state         <= RET_IDLE;
         r_is_rti        <= 1'b0;
         r_out           <= NOP_OP;
         r_stall         <= 1'b0;
         r_change_pc     <= 1'b0;
         r_flags_restore <= 1'b0;
      end else begin
         r_state         <= w_next;
         r_is_rti        <= w_is_rti_next;
         r_out           <= w_out;
         r_stall         <= w_stall;
         r_change_pc     <= w_change_pc;
         r_flags_restore <= w_flags_restore;
      end
   end

   assign out           = r_out;
   assign stall         = r_stall;
   assign change_pc_ret = r_change_pc;
   assign flags_restore = r_flags_restore;

endmodule

// File: doc/ret_fsm.md
Name: ret_fsm

Overview:
- Return-side counterpart of the call sequencer; sits in decode, in front of the ID/EX register.
- On RET or RTI, stalls fetch and injects stack-pop micro-ops into the pipeline.
- Collects the popped PC halves (and the flags word for RTI) as they come back from the memory stage.
- Then pulses change_pc_ret for one cycle so fetch loads the restored 32-bit PC.

Parameters:
- POP_PC_HIGH_OP, 16'b0110000000001010, micro-op that pops the PC high half.
- POP_PC_LOW_OP, 16'b0110000000001011, micro-op that pops the PC low half.
- POP_FLAGS_OP, 16'b0110000000001100, micro-op that pops the flags word (RTI only).
- FLAG_W, 4, width of the restored flags field.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- ret  input  1  RET decoded this cycle; sampled only in IDLE.
- rti  input  1  RTI decoded this cycle; sampled only in IDLE; wins over ret.
- pop_valid  input  1  memory stage returns one popped word this cycle.
- pop_data  input  16  popped word; returned in issue order.
- out  output  16  injected instruction; 16'b0 (NOP) when not injecting.
- stall  output  1  holds fetch/decode while a sequence is in progress.
- pc  output  32  restored PC, {high_half, low_half}.
- change_pc_ret  output  1  one-cycle pulse: fetch loads pc.
- flags_out  output  FLAG_W  restored flags, pop_data[FLAG_W-1:0] of the flags pop.
- flags_restore  output  1  one-cycle pulse, coincident with change_pc_ret, RTI only.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state returns to IDLE; registered outputs take their reset values.
  - out=0, stall=0, pc=0, change_pc_ret=0, flags_out=0, flags_restore=0.
  - internal return counter and is_rti flag are cleared.
  - This applies mid-sequence; any pop_valid data in flight is discarded.
- States: IDLE, POP_HIGH, POP_LOW, POP_FLAGS, WAIT_DATA, CHANGE_PC. Everything is registered; outputs change one cycle after the edge that causes them.
- IDLE:
  - out=0, stall=0.
  - If rti: is_rti<=1 and go to POP_HIGH. Else if ret: is_rti<=0 and go to POP_HIGH.
  - stall rises in the cycle after ret/rti is sampled.
- POP_HIGH: out=POP_PC_HIGH_OP, stall=1; go to POP_LOW.
- POP_LOW: out=POP_PC_LOW_OP, stall=1; go to POP_FLAGS if is_rti, else WAIT_DATA.
- POP_FLAGS: out=POP_FLAGS_OP, stall=1; go to WAIT_DATA.
- WAIT_DATA: out=0, stall=1; stay until the returned-word count equals expected (2 for RET, 3 for RTI), then go to CHANGE_PC.
- Capture runs independently of state, so words may return while pops are still being issued. On each pop_valid with count < expected:
  - count 0 writes pc[31:16].
  - count 1 writes pc[15:0].
  - count 2 writes flags_out.
  - count then increments.
- pop_valid in IDLE, in CHANGE_PC, or with count==expected is ignored.
- CHANGE_PC:
  - change_pc_ret=1 and stall=1 for exactly one cycle; flags_restore=is_rti.
  - out=0; next state IDLE, where stall=0 and the pulses drop.
  - pc and flags_out hold their values until the next sequence's first capture.
- ret or rti asserted while not in IDLE is ignored; decode holds it under stall.
- Minimum RET latency, from the sample edge to the change_pc_ret cycle, is 4 cycles, given pop data back by the end of POP_LOW. RTI minimum is 5.

Decomposition:
- Shared package (processor_pkg) holds:
  - all stack micro-op constants: PUSH_PC_LOW_OP, PUSH_PC_HIGH_OP, POP_PC_HIGH_OP, POP_PC_LOW_OP, POP_FLAGS_OP;
  - the NOP encoding;
  - ret_fsm state encodings;
  - FLAG_W.
- call_fsm and ret_fsm share these constants.
- One sub-module is natural: pop_collector, covering the counter, capture registers and done flag. The FSM keeps sequencing and outputs.

Test Plan:
- Reset with ret=1 held -> all outputs 0; FSM stays IDLE, no micro-op issued.
- ret pulse; pop_valid returns 16'h0001 then 16'h2345 with 1-cycle latency -> out sequence POP_PC_HIGH_OP, POP_PC_LOW_OP, 0; pc=32'h00012345; single change_pc_ret pulse; flags_restore=0; stall high from the cycle after ret through the pulse.
- rti with returns 16'h0000, 16'h0100, 16'h000B -> out sequence includes POP_FLAGS_OP; pc=32'h00000100; flags_out=4'hB; flags_restore coincides with change_pc_ret.
- ret and rti asserted together -> RTI sequence (3 pops). A second ret during stall -> ignored, exactly one change_pc_ret.
- Delayed returns (pop_valid 5 cycles late) -> FSM holds WAIT_DATA with stall=1 and out=0, then pulses correctly. Stray pop_valid in IDLE -> pc unchanged.
- reset asserted in WAIT_DATA after one word returned -> next cycle all outputs 0. A following ret with 16'hABCD, 16'h0042 -> pc=32'hABCD0042, with no residue from the aborted sequence.
